// File: rtl/magic_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// magic_ctrl_pkg
// Shared types and constants for the magic/NMI controller.
//   magic_state_t : mapping state machine states
//   CFG_IDX_*     : well-known indices into the config register file
// ---------------------------------------------------------------------------
package magic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NMI_REQ,
        MAPPED,
        UNMAP,
        REMAP_WAIT
    } magic_state_t;

    // Config register indices. 0 and 1 are synthesised (status, cause);
    // the rest are plain stored bytes consumed by other blocks.
    localparam int CFG_IDX_STATUS  = 0;
    localparam int CFG_IDX_CAUSE   = 1;
    localparam int CFG_IDX_MACHINE = 2;
    localparam int CFG_IDX_TURBO   = 3;
    localparam int CFG_IDX_PANNING = 4;
    localparam int CFG_IDX_AUDIO   = 5;

endpackage

// File: rtl/magic_ctrl_if.sv
// ---------------------------------------------------------------------------
// magic_ctrl_if
// CPU bus as seen by the magic controller.
//   a      : address bus
//   d      : write data from the CPU
//   rd, wr : read / write strobes
//   m1     : opcode fetch cycle
//   memreq : memory request
//   ioreq  : I/O request
// master drives the bus (CPU side), slave observes it (controller side).
// ---------------------------------------------------------------------------
interface magic_ctrl_if;
    logic [15:0] a;
    logic [7:0]  d;
    logic        rd;
    logic        wr;
    logic        m1;
    logic        memreq;
    logic        ioreq;

    modport master (output a, d, rd, wr, m1, memreq, ioreq);
    modport slave  (input  a, d, rd, wr, m1, memreq, ioreq);
endinterface

// File: rtl/magic_cfg_regs.sv
// ---------------------------------------------------------------------------
// magic_cfg_regs
// Byte-wide config register file behind the config I/O port.
//   clk28, rst   : clock, synchronous active-high reset
//   cs           : config port selected (already qualified by the ROM map)
//   rd, wr       : bus strobes
//   idx          : register index (high address byte)
//   wdata        : write data
//   status,cause : live bytes returned for idx 0 and idx 1
//   cause_wr     : one-cycle strobe, write-1-to-clear of the cause using wdata
//   cfg          : all config bytes, flat
//   d_out        : registered read data, d_out_active marks it valid
// ---------------------------------------------------------------------------
module magic_cfg_regs
    import magic_ctrl_pkg::*;
#(
    parameter int                    CFG_REGS     = 16,
    parameter logic [CFG_REGS*8-1:0] CFG_DEFAULTS = '0
) (
    input  logic                    clk28,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    rd,
    input  logic                    wr,
    input  logic [7:0]              idx,
    input  logic [7:0]              wdata,
    input  logic [7:0]              status,
    input  logic [7:0]              cause,
    output logic                    cause_wr,
    output logic [CFG_REGS*8-1:0]   cfg,
    output logic [7:0]              d_out,
    output logic                    d_out_active
);

    localparam int IDX_W = $clog2(CFG_REGS);

    logic             wr_seen_reg;
    logic             wr_stb;
    logic             idx_ok;
    logic [IDX_W-1:0] widx;
    logic [7:0]       rd_data;
    logic [7:0]       d_out_reg;
    logic             d_out_active_reg;

    assign idx_ok = ({1'b0, idx} < 9'(CFG_REGS));
    assign widx   = idx[IDX_W-1:0];

    // A write cycle keeps wr asserted for several clocks; only the first
    // clock of each access commits.
    assign wr_stb   = cs & wr & ~wr_seen_reg;
    assign cause_wr = wr_stb & (idx == 8'(CFG_IDX_CAUSE));

    always_ff @(posedge clk28) begin
        if (rst) begin
            wr_seen_reg <= 1'b0;
        end else begin
            wr_seen_reg <= cs & wr;
        end
    end

    generate
        for (genvar gi = 0; gi < CFG_REGS; gi++) begin : g_byte
            if (gi < 2) begin : g_fixed
                // Status and cause are served live from the controller;
                // their slots in the flat vector stay at the default value.
                assign cfg[gi*8 +: 8] = CFG_DEFAULTS[gi*8 +: 8];
            end else begin : g_stored
                logic [7:0] byte_reg;
                always_ff @(posedge clk28) begin
                    if (rst) begin
                        byte_reg <= CFG_DEFAULTS[gi*8 +: 8];
                    end else if (wr_stb && idx_ok && widx == IDX_W'(gi)) begin
                        byte_reg <= wdata;
                    end
                end
                assign cfg[gi*8 +: 8] = byte_reg;
            end
        end
    endgenerate

    always_comb begin
        rd_data = cfg[{widx, 3'b000} +: 8];
        if (idx == 8'(CFG_IDX_STATUS)) begin
            rd_data = status;
        end else if (idx == 8'(CFG_IDX_CAUSE)) begin
            rd_data = cause;
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            d_out_reg        <= 8'h00;
            d_out_active_reg <= 1'b0;
        end else begin
            d_out_active_reg <= cs & rd & idx_ok;
            if (cs && rd && idx_ok) begin
                d_out_reg <= rd_data;
            end
        end
    end

    assign d_out        = d_out_reg;
    assign d_out_active = d_out_active_reg;

endmodule

// File: rtl/magic_ctrl.sv
// ---------------------------------------------------------------------------
// magic_ctrl
// Multi-trigger magic/NMI controller: latches trigger causes, raises NMI at a
// frame boundary, maps the magic ROM while the session runs, watches for the
// NMI acknowledge fetch and exposes a config register file on an I/O port.
//   clk28, rst        : clock, synchronous active-high reset
//   bus               : CPU bus (slave modport)
//   n_int, n_int_next : frame interrupt now / one cycle ahead
//   trig              : trigger levels
//   div_paged         : divmmc paged status (reported in the status byte)
//   n_nmi             : NMI to the CPU, active low
//   magic_mode        : session active
//   magic_map         : map the magic ROM (combinational)
//   cfg               : config bytes, flat
//   d_out,d_out_active: config read data and bus drive enable
// ---------------------------------------------------------------------------
module magic_ctrl
    import magic_ctrl_pkg::*;
#(
    parameter int                    TRIG_COUNT     = 2,
    parameter int                    CFG_REGS       = 16,
    parameter logic [CFG_REGS*8-1:0] CFG_DEFAULTS   = '0,
    parameter logic [7:0]            CFG_PORT       = 8'hFF,
    parameter logic [15:0]           NMI_VECTOR     = 16'h0066,
    parameter logic [15:0]           EXIT_ADDR      = 16'hF000,
    parameter logic [15:0]           REMAP_ADDR     = 16'hF008,
    parameter int                    NMI_TIMEOUT    = 1024,
    parameter bit                    MAGIC_ON_START = 1'b1
) (
    input  logic                  clk28,
    input  logic                  rst,
    magic_ctrl_if.slave           bus,
    input  logic                  n_int,
    input  logic                  n_int_next,
    input  logic [TRIG_COUNT-1:0] trig,
    input  logic                  div_paged,
    output logic                  n_nmi,
    output logic                  magic_mode,
    output logic                  magic_map,
    output logic [CFG_REGS*8-1:0] cfg,
    output logic [7:0]            d_out,
    output logic                  d_out_active
);

    localparam int WD_W = $clog2(NMI_TIMEOUT + 1);

    magic_state_t          state_reg;
    logic                  n_nmi_reg;
    logic                  magic_mode_reg;
    logic                  remap_reg;
    logic [WD_W-1:0]       wdog_reg;
    logic [TRIG_COUNT-1:0] trig_reg;
    logic [TRIG_COUNT-1:0] pend_reg;
    logic [TRIG_COUNT-1:0] cause_reg;

    logic                  frame_edge;
    logic                  nmi_fetch;
    logic                  any_fetch;
    logic                  cs;
    logic                  cause_wr;
    logic [TRIG_COUNT-1:0] rise;
    logic [TRIG_COUNT-1:0] clr;
    logic [TRIG_COUNT-1:0] pend_kept;
    logic [TRIG_COUNT-1:0] cause_kept;
    logic [7:0]            status;

    assign frame_edge = n_int & ~n_int_next;
    assign any_fetch  = bus.m1 & bus.memreq;
    assign nmi_fetch  = any_fetch & (bus.a == NMI_VECTOR);
    assign rise       = trig & ~trig_reg;

    // Cause write-1-to-clear also drops matching pending bits; a rising
    // edge in the same cycle is OR-ed back in afterwards so the set wins.
    assign clr        = cause_wr ? bus.d[TRIG_COUNT-1:0] : '0;
    assign pend_kept  = pend_reg & ~clr;
    assign cause_kept = cause_reg & ~clr;

    // Combinational so the ROM is already mapped during the very fetch that
    // acknowledges the NMI or ends the one-instruction remap gap.
    always_comb begin
        magic_map = 1'b0;
        case (state_reg)
            MAPPED, UNMAP: magic_map = 1'b1;
            NMI_REQ:       magic_map = nmi_fetch;
            REMAP_WAIT:    magic_map = any_fetch;
            default:       magic_map = 1'b0;
        endcase
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_reg      <= MAGIC_ON_START ? MAPPED : IDLE;
            n_nmi_reg      <= 1'b1;
            magic_mode_reg <= MAGIC_ON_START;
            remap_reg      <= 1'b0;
            wdog_reg       <= '0;
            trig_reg       <= '0;
            pend_reg       <= '0;
            cause_reg      <= '0;
        end else begin
            trig_reg  <= trig;
            pend_reg  <= pend_kept | rise;
            cause_reg <= cause_kept;
            case (state_reg)
                IDLE: begin
                    wdog_reg <= '0;
                    if (frame_edge && (|pend_reg)) begin
                        n_nmi_reg      <= 1'b0;
                        magic_mode_reg <= 1'b1;
                        cause_reg      <= pend_kept;
                        pend_reg       <= rise;
                        state_reg      <= NMI_REQ;
                    end
                end
                NMI_REQ: begin
                    if (nmi_fetch) begin
                        n_nmi_reg <= 1'b1;
                        wdog_reg  <= '0;
                        state_reg <= MAPPED;
                    end else if (wdog_reg == WD_W'(NMI_TIMEOUT - 1)) begin
                        // No acknowledge: abandon the session but keep the
                        // causes pending so the next frame retries.
                        n_nmi_reg      <= 1'b1;
                        magic_mode_reg <= 1'b0;
                        pend_reg       <= pend_kept | rise | cause_kept;
                        wdog_reg       <= '0;
                        state_reg      <= IDLE;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                MAPPED: begin
                    if (bus.memreq && bus.rd && bus.a == EXIT_ADDR) begin
                        magic_mode_reg <= 1'b0;
                        state_reg      <= UNMAP;
                    end else if (bus.memreq && bus.rd && bus.a == REMAP_ADDR) begin
                        remap_reg <= 1'b1;
                        state_reg <= UNMAP;
                    end
                end
                UNMAP: begin
                    if (!bus.memreq) begin
                        state_reg <= remap_reg ? REMAP_WAIT : IDLE;
                    end
                end
                REMAP_WAIT: begin
                    if (any_fetch) begin
                        remap_reg <= 1'b0;
                        state_reg <= MAPPED;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign n_nmi      = n_nmi_reg;
    assign magic_mode = magic_mode_reg;

    assign cs     = magic_map & bus.ioreq & (bus.a[7:0] == CFG_PORT);
    assign status = 8'h80 | {1'b0, div_paged, 6'b000000} | 8'(trig);

    magic_cfg_regs #(
        .CFG_REGS     (CFG_REGS),
        .CFG_DEFAULTS (CFG_DEFAULTS)
    ) u_cfg_regs (
        .clk28        (clk28),
        .rst          (rst),
        .cs           (cs),
        .rd           (bus.rd),
        .wr           (bus.wr),
        .idx          (bus.a[15:8]),
        .wdata        (bus.d),
        .status       (status),
        .cause        (8'(cause_reg)),
        .cause_wr     (cause_wr),
        .cfg          (cfg),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

endmodule

// File: tb/tb_magic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_magic_ctrl
// Directed bench for magic_ctrl (TRIG_COUNT=2, CFG_REGS=16, NMI_TIMEOUT=16,
// MAGIC_ON_START=0). Config reads push their expected byte into a queue; a
// monitor pops and compares whenever d_out_active rises. Control outputs are
// checked inline against hand-computed values.
// ---------------------------------------------------------------------------
module tb_magic_ctrl;

    localparam int CFG_REGS = 16;

    logic                  clk28 = 1'b0;
    logic                  rst;
    logic                  n_int;
    logic                  n_int_next;
    logic [1:0]            trig;
    logic                  div_paged;
    logic                  n_nmi;
    logic                  magic_mode;
    logic                  magic_map;
    logic [CFG_REGS*8-1:0] cfg;
    logic [7:0]            d_out;
    logic                  d_out_active;

    magic_ctrl_if bus();

    always #5 clk28 = ~clk28;

    magic_ctrl #(
        .TRIG_COUNT     (2),
        .CFG_REGS       (CFG_REGS),
        .CFG_DEFAULTS   ('0),
        .CFG_PORT       (8'hFF),
        .NMI_VECTOR     (16'h0066),
        .EXIT_ADDR      (16'hF000),
        .REMAP_ADDR     (16'hF008),
        .NMI_TIMEOUT    (16),
        .MAGIC_ON_START (1'b0)
    ) dut (
        .clk28        (clk28),
        .rst          (rst),
        .bus          (bus),
        .n_int        (n_int),
        .n_int_next   (n_int_next),
        .trig         (trig),
        .div_paged    (div_paged),
        .n_nmi        (n_nmi),
        .magic_mode   (magic_mode),
        .magic_map    (magic_map),
        .cfg          (cfg),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

    int                    n_tests = 0;
    int                    n_fail  = 0;
    logic [7:0]            exp_q[$];
    logic [7:0]            mon_exp;
    logic                  act_prev = 1'b0;
    logic [CFG_REGS*8-1:0] cfg_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic bus_idle();
        bus.a      = 16'h0000;
        bus.d      = 8'h00;
        bus.rd     = 1'b0;
        bus.wr     = 1'b0;
        bus.m1     = 1'b0;
        bus.memreq = 1'b0;
        bus.ioreq  = 1'b0;
    endtask

    task automatic frame_pulse();
        n_int_next = 1'b0;
        tick();
        n_int_next = 1'b1;
        $display("[TB] frame edge");
    endtask

    task automatic trig_pulse(input logic [1:0] v);
        trig = v;
        tick();
        trig = 2'b00;
        tick();
        $display("[TB] trigger pulse %b", v);
    endtask

    task automatic fetch_nmi();
        bus.a = 16'h0066; bus.m1 = 1'b1; bus.memreq = 1'b1; bus.rd = 1'b1;
        #1;
        check("map_on_nmi_fetch", 128'(magic_map), 128'(1));
        tick();
        bus_idle();
        $display("[TB] M1 fetch at 0066");
    endtask

    task automatic cfg_wr(input logic [7:0] idx, input logic [7:0] data);
        bus.a = {idx, 8'hFF}; bus.d = data; bus.ioreq = 1'b1; bus.wr = 1'b1;
        tick();
        tick();
        bus_idle();
        tick();
        $display("[TB] cfg write idx=%0d data=%02h", idx, data);
    endtask

    task automatic cfg_rd(input logic [7:0] idx, input logic [7:0] exp);
        exp_q.push_back(exp);
        bus.a = {idx, 8'hFF}; bus.ioreq = 1'b1; bus.rd = 1'b1;
        tick();
        tick();
        bus_idle();
        tick();
        tick();
        $display("[TB] cfg read idx=%0d expect=%02h", idx, exp);
    endtask

    // Read that must not produce data (unmapped or out-of-range index).
    task automatic cfg_rd_dead(input logic [7:0] idx);
        bus.a = {idx, 8'hFF}; bus.ioreq = 1'b1; bus.rd = 1'b1;
        tick();
        check("no_read_active", 128'(d_out_active), 128'(0));
        tick();
        check("no_read_active", 128'(d_out_active), 128'(0));
        bus_idle();
        tick();
        $display("[TB] ignored cfg read idx=%0d", idx);
    endtask

    task automatic mem_read(input logic [15:0] addr);
        bus.a = addr; bus.memreq = 1'b1; bus.rd = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: one comparison per read response.
    always @(negedge clk28) begin
        if (d_out_active && !act_prev) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL read_unexpected: got %02h, expected no response", d_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("read_data", 128'(d_out), 128'(mon_exp));
            end
        end
        act_prev <= d_out_active;
    end

    initial begin
        bus_idle();
        rst        = 1'b1;
        n_int      = 1'b1;
        n_int_next = 1'b1;
        trig       = 2'b00;
        div_paged  = 1'b1;
        cfg_exp    = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        $display("[TB] reset released");
        check("reset_n_nmi", 128'(n_nmi), 128'(1));
        check("reset_magic_mode", 128'(magic_mode), 128'(0));
        check("reset_magic_map", 128'(magic_map), 128'(0));
        check("reset_d_out_active", 128'(d_out_active), 128'(0));
        check("reset_cfg", 128'(cfg), 128'(cfg_exp));

        // Session entry from trig[1].
        trig_pulse(2'b10);
        check("no_nmi_without_frame", 128'(n_nmi), 128'(1));
        frame_pulse();
        check("nmi_asserted", 128'(n_nmi), 128'(0));
        check("mode_on", 128'(magic_mode), 128'(1));
        check("map_off_before_ack", 128'(magic_map), 128'(0));
        fetch_nmi();
        check("nmi_released", 128'(n_nmi), 128'(1));
        check("map_mapped", 128'(magic_map), 128'(1));

        // Config while mapped.
        cfg_rd(8'd1, 8'h02);
        cfg_rd(8'd0, 8'hC0);
        cfg_wr(8'd5, 8'hA5);
        cfg_exp[5*8 +: 8] = 8'hA5;
        cfg_rd(8'd5, 8'hA5);
        check("cfg_byte5", 128'(cfg), 128'(cfg_exp));
        cfg_wr(8'd1, 8'h02);
        cfg_rd(8'd1, 8'h00);
        cfg_wr(8'd0, 8'hFF);
        cfg_rd(8'd0, 8'hC0);
        cfg_wr(8'd200, 8'h77);
        check("cfg_after_ignored_writes", 128'(cfg), 128'(cfg_exp));
        cfg_rd_dead(8'd200);

        // Exit.
        mem_read(16'hF000);
        check("exit_mode_off", 128'(magic_mode), 128'(0));
        check("exit_map_held", 128'(magic_map), 128'(1));
        bus_idle();
        #1;
        check("exit_map_held_no_memreq", 128'(magic_map), 128'(1));
        tick();
        check("exit_map_off", 128'(magic_map), 128'(0));
        $display("[TB] exit read F000");

        // Unmapped config access is ignored.
        cfg_wr(8'd6, 8'h11);
        check("cfg_unmapped_write", 128'(cfg), 128'(cfg_exp));
        cfg_rd_dead(8'd5);

        // Remap for one instruction.
        trig_pulse(2'b01);
        frame_pulse();
        check("nmi_asserted_2", 128'(n_nmi), 128'(0));
        fetch_nmi();
        cfg_rd(8'd1, 8'h01);
        mem_read(16'hF008);
        check("remap_mode_kept", 128'(magic_mode), 128'(1));
        bus_idle();
        tick();
        check("remap_gap_unmapped", 128'(magic_map), 128'(0));
        bus.a = 16'h1234; bus.m1 = 1'b1; bus.memreq = 1'b1; bus.rd = 1'b1;
        #1;
        check("remap_fetch_mapped", 128'(magic_map), 128'(1));
        tick();
        bus_idle();
        #1;
        check("remap_back_mapped", 128'(magic_map), 128'(1));
        $display("[TB] remap via F008, fetch at 1234");
        mem_read(16'hF000);
        bus_idle();
        tick();
        check("exit2_map_off", 128'(magic_map), 128'(0));

        // Watchdog timeout: no acknowledge fetch.
        trig_pulse(2'b10);
        frame_pulse();
        check("wd_nmi_asserted", 128'(n_nmi), 128'(0));
        repeat (15) tick();
        check("wd_nmi_still_low", 128'(n_nmi), 128'(0));
        tick();
        check("wd_nmi_released", 128'(n_nmi), 128'(1));
        check("wd_mode_off", 128'(magic_mode), 128'(0));
        $display("[TB] watchdog expired");
        tick();
        frame_pulse();
        check("wd_retry_nmi", 128'(n_nmi), 128'(0));
        fetch_nmi();
        cfg_rd(8'd1, 8'h02);

        // Reset during NMI_REQ.
        mem_read(16'hF000);
        bus_idle();
        tick();
        trig_pulse(2'b01);
        frame_pulse();
        check("pre_reset_nmi", 128'(n_nmi), 128'(0));
        rst = 1'b1;
        tick();
        check("rst_n_nmi", 128'(n_nmi), 128'(1));
        check("rst_mode", 128'(magic_mode), 128'(0));
        check("rst_cfg", 128'(cfg), 128'(0));
        rst = 1'b0;
        bus.a = 16'h0066; bus.m1 = 1'b1; bus.memreq = 1'b1; bus.rd = 1'b1;
        #1;
        check("rst_state_idle", 128'(magic_map), 128'(0));
        bus_idle();
        $display("[TB] reset during NMI request");

        repeat (3) tick();
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/magic_ctrl.md
Name: magic_ctrl

Overview:
Parametrised successor to the single-button magic/NMI controller. It accepts TRIG_COUNT trigger sources and latches a per-source cause, which the ROM reads back. It adds an NMI-acknowledge watchdog and an explicit mapping state machine. It owns a generic byte-wide config register file at I/O port xxCFG_PORT, readable and writable only while the magic ROM is mapped. It sits between the CPU bus, the ULA frame interrupt and the memory mapper, and feeds config bytes to the machine, turbo, audio and peripheral blocks.

Parameters:
TRIG_COUNT, 2, number of trigger inputs (1..6)
CFG_REGS, 16, number of config byte registers (4..256)
CFG_DEFAULTS, all 0, CFG_REGS*8-bit vector of reset values (byte i at [8i+7:8i])
CFG_PORT, 8'hFF, low address byte of the config port
NMI_VECTOR, 16'h0066, fetch address that acknowledges NMI and maps the ROM
EXIT_ADDR, 16'hF000, read that leaves magic mode
REMAP_ADDR, 16'hF008, read that unmaps for one instruction, then remaps
NMI_TIMEOUT, 1024, clk28 cycles to wait for the NMI acknowledge
MAGIC_ON_START, 1, leave reset mapped and in magic mode

Ports:
clk28  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
bus  cpu_bus  -  CPU bus interface (a, d, rd, wr, m1, memreq, ioreq)
n_int  in  1  current frame interrupt
n_int_next  in  1  frame interrupt one cycle ahead
trig  in  TRIG_COUNT  trigger levels (buttons, pause, external)
div_paged  in  1  divmmc paged status
n_nmi  out  1  NMI to the CPU, active low
magic_mode  out  1  magic session active
magic_map  out  1  map the magic ROM
cfg  out  CFG_REGS*8  config bytes, flat
d_out  out  8  read data
d_out_active  out  1  read data valid, drive the bus

Behaviour:
- Reset values: n_nmi=1; magic_mode=MAGIC_ON_START; state=MAPPED if MAGIC_ON_START, else IDLE; cfg=CFG_DEFAULTS; pend=0; cause=0; d_out_active=0; d_out=0; watchdog=0.
- frame_edge = n_int & ~n_int_next (single-cycle strobe).
- Trigger edge detect: trig is registered once; a rising edge sets pend[i]. Clearing pend[i] by a cause write in the same cycle as a new rising edge: the set wins.
- States:
  - IDLE: on frame_edge with |pend, set n_nmi=0, set magic_mode=1, copy cause<=pend, clear pend, go to NMI_REQ.
  - NMI_REQ: on m1 & memreq & a==NMI_VECTOR, set n_nmi=1 and go to MAPPED. Otherwise the watchdog counts up. When it reaches NMI_TIMEOUT-1: n_nmi=1, magic_mode=0, pend|=cause, go to IDLE.
  - MAPPED: on memreq & rd & a==EXIT_ADDR, clear magic_mode and go to UNMAP. On memreq & rd & a==REMAP_ADDR, set the remap flag and go to UNMAP.
  - UNMAP: map is held until memreq deasserts. Then go to REMAP_WAIT if the remap flag is set, else IDLE.
  - REMAP_WAIT: on the next m1 & memreq at any address, clear the remap flag and go to MAPPED.
- magic_map (combinational, timing-critical):
  - 1 in MAPPED and UNMAP.
  - Also 1 in NMI_REQ while m1 & memreq & a==NMI_VECTOR, and in REMAP_WAIT while m1 & memreq.
  - 0 in all other cases.
- Frame edges outside IDLE do not raise NMI. Triggers during a session stay pending and are serviced at the first frame edge after returning to IDLE.
- An exit read and a frame_edge in the same cycle: the exit is taken and the NMI is evaluated at a later frame.
- Config select: cs = magic_map & ioreq & a[7:0]==CFG_PORT; idx = a[15:8].
- Writes:
  - Committed once per I/O cycle, on the first cycle of cs & wr.
  - idx 0 (status) is read-only.
  - idx 1 (cause) is write-1-to-clear.
  - idx 2..CFG_REGS-1 store d.
  - idx >= CFG_REGS is ignored.
- Reads:
  - d_out and d_out_active are registered one cycle after cs & rd & idx<CFG_REGS.
  - d_out_active deasserts one cycle after rd or cs drops.
  - idx 0 returns {1'b1, div_paged, zero-padding, trig}, with trig in the low TRIG_COUNT bits.
  - idx 1 returns the cause, zero-extended.
  - Other valid idx returns the stored byte.
- Reset asserted mid-session returns every register to its reset value on the next edge, including n_nmi=1.

Decomposition:
- common package: magic_state_t enum {IDLE, NMI_REQ, MAPPED, UNMAP, REMAP_WAIT}.
- common package: constants CFG_IDX_STATUS=0 and CFG_IDX_CAUSE=1, plus named indices for the machine, turbo, panning and audio bytes.
- Sub-module magic_cfg_regs:
  - Contains the register file, the write-once-per-cycle logic and the read mux.
  - Parameters CFG_REGS and CFG_DEFAULTS.
  - Inputs cs, idx, status and cause.
- magic_ctrl keeps the state machine, the trigger latches and the watchdog.

Test Plan:
- MAGIC_ON_START=0: pulse trig[1], then frame_edge -> n_nmi=0 and magic_mode=1; M1 fetch at 16'h0066 -> magic_map=1 in the same cycle, n_nmi=1; reading idx 1 gives 8'h02.
- In MAPPED, read 16'hF000 -> magic_mode=0 that cycle; magic_map drops after memreq falls; state is IDLE.
- In MAPPED, read 16'hF008 -> unmapped for one instruction; the next M1 at 16'h1234 gives magic_map=1 combinationally; state is MAPPED.
- NMI_TIMEOUT=16 with no fetch at 0x0066 -> n_nmi returns to 1 after 16 cycles, magic_mode=0, pend restored; the next frame_edge asserts NMI again.
- Config while mapped:
  - Write 8'hA5 to idx 5, then read it back -> d_out=8'hA5 and d_out_active=1 one cycle after rd.
  - Write 8'h02 to idx 1 -> cause bit 1 cleared.
  - Write to idx 0 or idx 200 (CFG_REGS=16) -> no change.
  - The same access with magic_map=0 -> ignored, d_out_active stays 0.
- Assert rst during NMI_REQ -> n_nmi=1, cfg equals CFG_DEFAULTS and state equals the MAGIC_ON_START default on the next cycle.
